// File: rtl/avg_decim_fifo_if.sv
// Stream interface of the average/decimate output stage: sum input, FIFO read side, status.
interface avg_decim_fifo_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [7:0]        drop_cnt;

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, level, overflow, drop_cnt
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, level, overflow, drop_cnt
    );
endinterface

// File: rtl/avg_decim_fifo.sv
// Scales the moving-average running sum, keeps 1 of every DECIM valid samples and
// buffers kept samples in a first-word-fall-through FIFO with overflow accounting.
module avg_decim_fifo #(
    parameter int DATA_W     = 16,
    parameter int SHIFT      = 3,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    avg_decim_fifo_if.slave   bus
);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0]  r_dcnt;
    logic [DATA_W-1:0] r_stage_data;
    logic              r_stage_vld;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic w_keep, w_full, w_empty, w_pop, w_push, w_drop;

    assign w_keep  = bus.in_valid && (r_dcnt == CNT_LAST);
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && bus.out_ready;
    // A pop in the same cycle frees the slot the full FIFO's write targets.
    assign w_push  = r_stage_vld && (!w_full || w_pop);
    assign w_drop  = r_stage_vld && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dcnt       <= '0;
            r_stage_data <= '0;
            r_stage_vld  <= 1'b0;
        end else begin
            if (bus.in_valid)
                r_dcnt <= (r_dcnt == CNT_LAST) ? '0 : r_dcnt + 1'b1;
            r_stage_data <= bus.in_data >> SHIFT;
            r_stage_vld  <= w_keep;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push)
            r_mem[r_wr_ptr] <= r_stage_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Memory is not reset, so the head is masked to zero while empty.
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.out_valid = !w_empty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_avg_decim_fifo.sv
// Bench for avg_decim_fifo: constant tables, directed corner sequences and a random
// run against a queue-based reference; a DECIM=1 twin is scoreboarded alongside.
module tb_avg_decim_fifo;
    localparam int DATA_W = 16, SHIFT = 3, DECIM = 4, DEPTH = 4, ADDR_W = 2;

    logic clk, reset;
    int checks = 0, errors = 0;

    avg_decim_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    avg_decim_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();

    avg_decim_fifo #(.DATA_W(DATA_W), .SHIFT(SHIFT), .DECIM(DECIM),
                     .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W))
        dut (.i_clk(clk), .i_reset(reset), .bus(bus.slave));

    avg_decim_fifo #(.DATA_W(DATA_W), .SHIFT(SHIFT), .DECIM(1),
                     .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W))
        dut1 (.i_clk(clk), .i_reset(reset), .bus(b1.slave));

    assign b1.in_data   = bus.in_data;
    assign b1.in_valid  = bus.in_valid;
    assign b1.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: FIFO as a queue, one-slot pending stage, decimation from valid count.
    int  mq[$];
    bit  m_pend;
    int  m_pdata, m_nval, m_drop;
    bit  m_ov;

    task automatic mreset();
        mq.delete(); m_pend = 0; m_pdata = 0; m_nval = 0; m_ov = 0; m_drop = 0;
    endtask

    task automatic mcheck();
        chk("m_valid", {31'd0, bus.out_valid}, (mq.size() > 0) ? 1 : 0);
        chk("m_data",  {16'd0, bus.out_data}, (mq.size() > 0) ? mq[0] : 0);
        chk("m_level", {29'd0, bus.level}, mq.size());
        chk("m_ovf",   {31'd0, bus.overflow}, {31'd0, m_ov});
        chk("m_drop",  {24'd0, bus.drop_cnt}, m_drop);
    endtask

    task automatic mstep(input bit rst, input bit v, input logic [15:0] d, input bit r);
        if (rst) begin
            mreset();
        end else begin
            if (mq.size() > 0 && r) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back(m_pdata);
                else begin
                    m_ov = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            m_pend  = v && ((m_nval % DECIM) == DECIM - 1);
            m_pdata = int'(d) >> SHIFT;
            if (v) m_nval++;
        end
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [15:0] d, input bit r);
        reset = rst; bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
        mcheck();
        @(posedge clk); #1;
        mstep(rst, v, d, r);
    endtask

    // DECIM=1 twin: every valid input must come out, scaled, in order.
    int dq[$];
    always @(negedge clk) begin
        if (b1.out_valid === 1'b1) begin
            if (dq.size() == 0) chk("d1_spurious", {16'd0, b1.out_data}, 32'hFFFF_FFFF);
            else chk("d1_data", {16'd0, b1.out_data}, dq.pop_front());
        end
        if (reset) dq.delete();
        else if (bus.in_valid) dq.push_back(int'(bus.in_data) >> SHIFT);
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        ovld;
        logic [15:0] odata;
        logic [2:0]  lvl;
    } vec_t;
    vec_t tbl[18];

    initial begin
        int npop;
        logic [15:0] rd;
        for (int i = 0; i < 18; i++) begin
            tbl[i].v     = (i < 16);
            tbl[i].d     = 16'(8 * i);
            tbl[i].r     = 1'b1;
            tbl[i].ovld  = (i == 5 || i == 9 || i == 13 || i == 17);
            tbl[i].odata = tbl[i].ovld ? 16'(i - 2) : 16'd0;
            tbl[i].lvl   = tbl[i].ovld ? 3'd1 : 3'd0;
        end

        reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        mreset();
        @(posedge clk); #1;

        // Reset held with active input
        for (int i = 0; i < 3; i++) cycle(1, 1, 16'hFFFF, 0);
        chk("rst_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_data",  {16'd0, bus.out_data}, 0);
        chk("rst_level", {29'd0, bus.level}, 0);
        chk("rst_ovf",   {31'd0, bus.overflow}, 0);
        chk("rst_drop",  {24'd0, bus.drop_cnt}, 0);

        // Stream straight out of reset (dcnt must start at 0)
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl_valid[%0d]", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ovld});
            chk($sformatf("tbl_data[%0d]", i),  {16'd0, bus.out_data}, {16'd0, tbl[i].odata});
            chk($sformatf("tbl_level[%0d]", i), {29'd0, bus.level}, {29'd0, tbl[i].lvl});
            cycle(0, tbl[i].v, tbl[i].d, tbl[i].r);
        end
        chk("stream_ovf", {31'd0, bus.overflow}, 0);

        // Backpressure: fifth kept sample dropped
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 16'(8 * i), 0);
        cycle(0, 0, 0, 0);
        chk("bp_level", {29'd0, bus.level}, 4);
        chk("bp_ovf",   {31'd0, bus.overflow}, 1);
        chk("bp_drop",  {24'd0, bus.drop_cnt}, 1);
        for (int j = 0; j < 4; j++) begin
            chk("bp_data",  {16'd0, bus.out_data}, 4 * j + 3);
            chk("bp_lvl_dn", {29'd0, bus.level}, 4 - j);
            cycle(0, 0, 0, 1);
        end
        chk("bp_empty", {29'd0, bus.level}, 0);

        // Full FIFO with push and pop in the same cycle
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 16'(8 * i), 0);
        cycle(0, 0, 0, 0);
        chk("fp_full", {29'd0, bus.level}, 4);
        for (int i = 16; i < 20; i++) cycle(0, 1, 16'(8 * i), 0);
        chk("fp_head", {16'd0, bus.out_data}, 3);
        cycle(0, 0, 0, 1);
        chk("fp_level", {29'd0, bus.level}, 4);
        chk("fp_drop",  {24'd0, bus.drop_cnt}, 0);
        for (int j = 0; j < 4; j++) begin
            chk("fp_order", {16'd0, bus.out_data}, 4 * j + 7);
            cycle(0, 0, 0, 1);
        end

        // Gapped input: 1,0,0 pattern, only every 4th valid kept
        cycle(1, 0, 0, 0);
        npop = 0;
        for (int c = 0; c < 51; c++) begin
            if (bus.out_valid) npop++;
            cycle(0, (c % 3 == 0) && (c < 48), 16'(8 * (c / 3)), 1);
        end
        chk("gap_count", npop, 4);

        // Drop counter saturation
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 1100; i++) cycle(0, 1, 16'($urandom), 0);
        cycle(0, 0, 0, 0);
        chk("sat_drop", {24'd0, bus.drop_cnt}, 255);
        chk("sat_ovf",  {31'd0, bus.overflow}, 1);

        // Reset mid-run with level 3 and a kept sample in stage
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 16'h7770 + 16'(i), 0);
        chk("mr_level3", {29'd0, bus.level}, 3);
        cycle(1, 0, 0, 0);
        chk("mr_level", {29'd0, bus.level}, 0);
        chk("mr_valid", {31'd0, bus.out_valid}, 0);
        chk("mr_ovf",   {31'd0, bus.overflow}, 0);
        chk("mr_drop",  {24'd0, bus.drop_cnt}, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 16'(8 * (40 + i)), 1);
        chk("mr_nobyp", {31'd0, bus.out_valid}, 0);
        cycle(0, 0, 0, 1);
        chk("mr_valid2", {31'd0, bus.out_valid}, 1);
        chk("mr_data2",  {16'd0, bus.out_data}, 43);

        // Random traffic against the reference
        for (int i = 0; i < 2000; i++) begin
            rd = 16'($urandom);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rd,
                  $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
        chk("d1_drained", dq.size(), 0);
        chk("d1_ovf", {31'd0, b1.overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avg_decim_fifo.md
Name: avg_decim_fifo

Overview:
Output stage placed directly downstream of the moving-average filter. It takes the filter's raw running sum, scales it by a right shift, keeps one sample in every DECIM, and buffers kept samples in a small FIFO. Downstream consumers read the buffer through a valid/ready handshake. Overflow is reported by a sticky flag and a saturating drop counter.

Parameters:
DATA_W, 16, width of input sum and output sample
SHIFT, 3, logical right-shift applied to input (log2 of averaging length)
DECIM, 4, decimation factor, >=1; keep 1 of every DECIM valid inputs
FIFO_DEPTH, 4, FIFO entries, power of 2, >=2
ADDR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  DATA_W  running sum from moving-average filter
in_valid  input  1  in_data valid this cycle; no backpressure to upstream
out_data  output  DATA_W  head-of-FIFO sample (first-word-fall-through)
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky, set when a kept sample is dropped
drop_cnt  output  8  count of dropped samples, saturates at 255

Behaviour:
- Reset (sync, active-high): decim counter, stage register, rd/wr pointers, level, overflow, drop_cnt all 0. out_valid=0 and out_data=0 in the cycle after reset is sampled. Reset mid-operation discards FIFO contents and the pending stage sample. Reset overrides all other activity.
- Decimation: counter dcnt runs 0..DECIM-1 and advances only on in_valid=1, wrapping to 0. A sample is kept when in_valid=1 and dcnt==DECIM-1, i.e. the DECIM-th, 2*DECIM-th, ... valid input. With DECIM=1, every valid input is kept. Cycles with in_valid=0 do not advance dcnt.
- Scaling: stage_data <= in_data >> SHIFT (logical, zero-filled). stage_vld <= kept. This register is pipeline stage 1.
- Push: stage_vld=1 writes stage_data at wr_ptr on the next edge, unless the FIFO is full with no pop this cycle.
- Drop: stage_vld=1 while full with no pop discards the sample, sets overflow=1, and increments drop_cnt (holds at 255).
- Full plus pop in the same cycle: the push is accepted and level is unchanged.
- Pop: occurs when out_valid and out_ready. rd_ptr advances and wraps modulo FIFO_DEPTH; wr_ptr wraps the same way.
- Empty plus push: out_valid asserts the cycle after the write edge. There is no same-cycle bypass.
- Latency: a kept sample presented in cycle k appears on out_data with out_valid=1 in cycle k+2 when the FIFO is empty.
- Handshake: while out_valid=1 and out_ready=0, out_data and out_valid hold stable. out_ready while empty has no effect.
- Level: push only → +1; pop only → -1; both or neither → unchanged. level never exceeds FIFO_DEPTH and never underflows.
- overflow and drop_cnt clear only on reset.

Test Plan:
1. Reset: hold reset 3 cycles with in_valid=1 and in_data=0xFFFF → out_valid=0, out_data=0, level=0, overflow=0, drop_cnt=0. After release, dcnt starts from 0.
2. Stream: defaults, out_ready=1, in_valid=1, in_data=8*i for i=0..15 → outputs 3,7,11,15 (=8*(4j+3)>>3). First out_valid occurs 2 cycles after i=3 is presented. overflow=0.
3. Backpressure: out_ready=0, 20 valid inputs in_data=8*i → 5 kept, level=4, fifth dropped, overflow=1, drop_cnt=1. Then out_ready=1 → 3,7,11,15 in order, and level counts down to 0.
4. Full with simultaneous push/pop: fill to level 4, then assert out_ready for exactly the cycle a kept sample arrives → push accepted, level stays 4, drop_cnt unchanged, output order preserved.
5. Gaps: in_valid toggling 1,0,0,1,... with DECIM=4 → keep occurs only on the 4th valid sample; idle cycles do not advance dcnt. With DECIM=1, every valid input reaches the output.
6. Reset mid-run: level=3 and a kept sample in stage → pulse reset 1 cycle → level=0, out_valid=0, overflow/drop_cnt=0. The stage sample never appears at the output, and the next kept sample is the 4th valid input after reset.
